// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline MEM stage: captures one load or store,
// completes it LATENCY cycles later with a ready pulse and freezes the pipeline meanwhile.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_enable,
   input  logic        mem_write_enable,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] data,
   output logic        ready,
   output logic        stall,
   output logic        addr_error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        rd_q, wr_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] data_q;
   logic        ready_q, err_q;
   logic [31:0] mem [DEPTH_WORDS];

   logic          req;
   logic          go_resp;
   logic          eff_rd, eff_wr;
   logic [31:0]   eff_addr, eff_wdata;
   logic          err_c;
   logic [AW-1:0] idx;

   assign req = mem_read_enable | mem_write_enable;

   // With LATENCY=1 the capture edge is also the commit edge, so live inputs are used there.
   assign go_resp   = ((state_q == IDLE) && req && (LATENCY == 1)) ||
                      ((state_q == BUSY) && (cnt_q == 4'd0));
   assign eff_rd    = (state_q == IDLE) ? mem_read_enable  : rd_q;
   assign eff_wr    = (state_q == IDLE) ? mem_write_enable : wr_q;
   assign eff_addr  = (state_q == IDLE) ? address          : addr_q;
   assign eff_wdata = (state_q == IDLE) ? write_data       : wdata_q;

   assign idx   = eff_addr[AW+1:2];
   assign err_c = (|eff_addr[1:0]) || (|eff_addr[31:AW+2]) || (eff_rd && eff_wr);

   assign stall      = ((state_q == IDLE) && req) || (state_q == BUSY);
   assign data       = data_q;
   assign ready      = ready_q;
   assign addr_error = err_q;

   // Array has no reset; the reset gate keeps an in-reset capture from committing.
   always_ff @(posedge clk) begin
      if (go_resp && reset && eff_wr && !err_c)
         mem[idx] <= eff_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  rd_q    <= mem_read_enable;
                  wr_q    <= mem_write_enable;
                  addr_q  <= address;
                  wdata_q <= write_data;
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= 4'((LATENCY > 1) ? LATENCY - 2 : 0);
                  end
               end
            end
            BUSY: begin
               if (cnt_q == 4'd0) state_q <= RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (go_resp) begin
            ready_q <= 1'b1;
            err_q   <= err_c;
            if (err_c)       data_q <= 32'd0;
            else if (eff_rd) data_q <= mem[idx];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 4) each with their own request
// lines, one clock and one shared reset.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  re, we, rdy, stl, aerr;
   logic [31:0] ad [3];
   logic [31:0] wd [3];
   logic [31:0] dq [3];
   int checks = 0;
   int failures = 0;
   int n, st;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u0 (
      .clk(clk), .reset(reset), .mem_read_enable(re[0]), .mem_write_enable(we[0]),
      .address(ad[0]), .write_data(wd[0]), .data(dq[0]), .ready(rdy[0]),
      .stall(stl[0]), .addr_error(aerr[0]));
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
      .clk(clk), .reset(reset), .mem_read_enable(re[1]), .mem_write_enable(we[1]),
      .address(ad[1]), .write_data(wd[1]), .data(dq[1]), .ready(rdy[1]),
      .stall(stl[1]), .addr_error(aerr[1]));
   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u2 (
      .clk(clk), .reset(reset), .mem_read_enable(re[2]), .mem_write_enable(we[2]),
      .address(ad[2]), .write_data(wd[2]), .data(dq[2]), .ready(rdy[2]),
      .stall(stl[2]), .addr_error(aerr[2]));

   // Drive a request and wait (bounded) for ready; n = edges until ready (-1 on timeout),
   // st = cycles stall was seen high before ready.
   task automatic do_op(input int k, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output int stc);
      re[k] = rd; we[k] = wr; ad[k] = a; wd[k] = d;
      #1;
      stc = int'(stl[k]);
      cyc = -1;
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk); #1;
         if (rdy[k]) begin cyc = i; break; end
         stc += int'(stl[k]);
      end
   endtask

   task automatic idle(input int k);
      re[k] = 1'b0; we[k] = 1'b0; ad[k] = 32'd0; wd[k] = 32'd0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; re = 3'b0; we = 3'b0;
      for (int k = 0; k < 3; k++) begin ad[k] = 32'd0; wd[k] = 32'd0; end
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (rdy[k] !== 1'b0)   begin failures++; $display("FAIL rst_ready[%0d] got=%b exp=0", k, rdy[k]); end
         checks++; if (aerr[k] !== 1'b0)  begin failures++; $display("FAIL rst_err[%0d] got=%b exp=0", k, aerr[k]); end
         checks++; if (dq[k] !== 32'd0)   begin failures++; $display("FAIL rst_data[%0d] got=%h exp=0", k, dq[k]); end
         checks++; if (stl[k] !== 1'b0)   begin failures++; $display("FAIL rst_stall[%0d] got=%b exp=0", k, stl[k]); end
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      do_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, n, st);
      checks++; if (n !== 2)          begin failures++; $display("FAIL sl_store_lat got=%0d exp=2", n); end
      checks++; if (st !== 2)         begin failures++; $display("FAIL sl_store_stall got=%0d exp=2", st); end
      checks++; if (dq[0] !== 32'd0)  begin failures++; $display("FAIL sl_store_data got=%h exp=0", dq[0]); end
      checks++; if (stl[0] !== 1'b0)  begin failures++; $display("FAIL sl_resp_stall got=%b exp=0", stl[0]); end
      idle(0);
      do_op(0, 1'b1, 1'b0, 32'h10, 32'd0, n, st);
      checks++; if (n !== 2)               begin failures++; $display("FAIL sl_load_lat got=%0d exp=2", n); end
      checks++; if (st !== 2)              begin failures++; $display("FAIL sl_load_stall got=%0d exp=2", st); end
      checks++; if (dq[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_load_data got=%h exp=deadbeef", dq[0]); end
      checks++; if (aerr[0] !== 1'b0)      begin failures++; $display("FAIL sl_load_err got=%b exp=0", aerr[0]); end
      idle(0);
   endtask

   task automatic test_back_to_back();
      do_op(1, 1'b0, 1'b1, 32'h0, 32'h11, n, st);
      checks++; if (n !== 1)         begin failures++; $display("FAIL b2b_st0_lat got=%0d exp=1", n); end
      checks++; if (dq[1] !== 32'd0) begin failures++; $display("FAIL b2b_st0_data got=%h exp=0", dq[1]); end
      do_op(1, 1'b0, 1'b1, 32'h4, 32'h22, n, st);
      checks++; if (n !== 2)         begin failures++; $display("FAIL b2b_st1_lat got=%0d exp=2", n); end
      do_op(1, 1'b1, 1'b0, 32'h0, 32'd0, n, st);
      checks++; if (n !== 2)          begin failures++; $display("FAIL b2b_ld0_lat got=%0d exp=2", n); end
      checks++; if (dq[1] !== 32'h11) begin failures++; $display("FAIL b2b_ld0_data got=%h exp=11", dq[1]); end
      do_op(1, 1'b1, 1'b0, 32'h4, 32'd0, n, st);
      checks++; if (n !== 2)          begin failures++; $display("FAIL b2b_ld1_lat got=%0d exp=2", n); end
      checks++; if (dq[1] !== 32'h22) begin failures++; $display("FAIL b2b_ld1_data got=%h exp=22", dq[1]); end
      re[1] = 1'b0; we[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (rdy[1] !== 1'b0) begin failures++; $display("FAIL b2b_extra_ready cyc=%0d got=%b exp=0", i, rdy[1]); end
      end
   endtask

   task automatic test_errors();
      do_op(0, 1'b0, 1'b1, 32'h0, 32'h12345678, n, st);
      checks++; if (aerr[0] !== 1'b0) begin failures++; $display("FAIL err_st0 got=%b exp=0", aerr[0]); end
      idle(0);
      checks++; if (aerr[0] !== 1'b0) begin failures++; $display("FAIL err_pulse_clear got=%b exp=0", aerr[0]); end
      do_op(0, 1'b1, 1'b0, 32'h6, 32'd0, n, st);
      checks++; if (n !== 2)          begin failures++; $display("FAIL err_unal_lat got=%0d exp=2", n); end
      checks++; if (aerr[0] !== 1'b1) begin failures++; $display("FAIL err_unal_flag got=%b exp=1", aerr[0]); end
      checks++; if (dq[0] !== 32'd0)  begin failures++; $display("FAIL err_unal_data got=%h exp=0", dq[0]); end
      idle(0);
      do_op(0, 1'b1, 1'b0, 32'h0, 32'd0, n, st);
      checks++; if (dq[0] !== 32'h12345678) begin failures++; $display("FAIL err_ld0a got=%h exp=12345678", dq[0]); end
      idle(0);
      do_op(0, 1'b1, 1'b0, 32'h400, 32'd0, n, st);
      checks++; if (aerr[0] !== 1'b1) begin failures++; $display("FAIL err_range_flag got=%b exp=1", aerr[0]); end
      checks++; if (dq[0] !== 32'd0)  begin failures++; $display("FAIL err_range_data got=%h exp=0", dq[0]); end
      idle(0);
      do_op(0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, n, st);
      checks++; if (aerr[0] !== 1'b1) begin failures++; $display("FAIL err_both_flag got=%b exp=1", aerr[0]); end
      idle(0);
      do_op(0, 1'b0, 1'b1, 32'h2, 32'hBAD, n, st);
      checks++; if (aerr[0] !== 1'b1) begin failures++; $display("FAIL err_unal_st got=%b exp=1", aerr[0]); end
      idle(0);
      do_op(0, 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, n, st);
      checks++; if (aerr[0] !== 1'b0) begin failures++; $display("FAIL err_top_st got=%b exp=0", aerr[0]); end
      idle(0);
      do_op(0, 1'b1, 1'b0, 32'h3FC, 32'd0, n, st);
      checks++; if (dq[0] !== 32'hCAFEF00D) begin failures++; $display("FAIL err_top_ld got=%h exp=cafef00d", dq[0]); end
      idle(0);
      do_op(0, 1'b1, 1'b0, 32'h0, 32'd0, n, st);
      checks++; if (dq[0] !== 32'h12345678) begin failures++; $display("FAIL err_ld0b got=%h exp=12345678", dq[0]); end
      checks++; if (aerr[0] !== 1'b0)       begin failures++; $display("FAIL err_ld0b_flag got=%b exp=0", aerr[0]); end
      idle(0);
   endtask

   task automatic test_capture();
      do_op(2, 1'b0, 1'b1, 32'h20, 32'h55AA55AA, n, st);
      checks++; if (n !== 4)  begin failures++; $display("FAIL cap_st_lat got=%0d exp=4", n); end
      checks++; if (st !== 4) begin failures++; $display("FAIL cap_st_stall got=%0d exp=4", st); end
      idle(2);
      do_op(2, 1'b0, 1'b1, 32'h24, 32'h77, n, st);
      idle(2);
      re[2] = 1'b1; we[2] = 1'b0; ad[2] = 32'h20; wd[2] = 32'd0;
      @(posedge clk); #1;
      n = rdy[2] ? 1 : -1;
      ad[2] = 32'h24; wd[2] = 32'h99;
      for (int i = 2; i <= 50 && n < 0; i++) begin
         @(posedge clk); #1;
         if (rdy[2]) n = i;
      end
      checks++; if (n !== 4)                begin failures++; $display("FAIL cap_ld_lat got=%0d exp=4", n); end
      checks++; if (dq[2] !== 32'h55AA55AA) begin failures++; $display("FAIL cap_ld_data got=%h exp=55aa55aa", dq[2]); end
      idle(2);
      do_op(2, 1'b1, 1'b0, 32'h24, 32'd0, n, st);
      checks++; if (dq[2] !== 32'h77) begin failures++; $display("FAIL cap_ld24 got=%h exp=77", dq[2]); end
      idle(2);
   endtask

   task automatic test_reset_abort();
      do_op(0, 1'b0, 1'b1, 32'h8, 32'h11112222, n, st);
      idle(0);
      do_op(0, 1'b1, 1'b0, 32'h8, 32'd0, n, st);
      checks++; if (dq[0] !== 32'h11112222) begin failures++; $display("FAIL ab_pre got=%h exp=11112222", dq[0]); end
      idle(0);
      re[0] = 1'b0; we[0] = 1'b1; ad[0] = 32'h8; wd[0] = 32'hA5A5A5A5;
      @(posedge clk); #1;
      checks++; if (stl[0] !== 1'b1) begin failures++; $display("FAIL ab_busy_stall got=%b exp=1", stl[0]); end
      reset = 1'b0;
      #1;
      checks++; if (dq[0] !== 32'd0)  begin failures++; $display("FAIL ab_data got=%h exp=0", dq[0]); end
      checks++; if (rdy[0] !== 1'b0)  begin failures++; $display("FAIL ab_ready got=%b exp=0", rdy[0]); end
      checks++; if (stl[0] !== 1'b1)  begin failures++; $display("FAIL ab_req_stall got=%b exp=1", stl[0]); end
      we[0] = 1'b0;
      #1;
      checks++; if (stl[0] !== 1'b0)  begin failures++; $display("FAIL ab_idle_stall got=%b exp=0", stl[0]); end
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL ab_no_ready cyc=%0d got=%b exp=0", i, rdy[0]); end
      end
      do_op(0, 1'b1, 1'b0, 32'h8, 32'd0, n, st);
      checks++; if (n !== 2)                begin failures++; $display("FAIL ab_post_lat got=%0d exp=2", n); end
      checks++; if (dq[0] !== 32'h11112222) begin failures++; $display("FAIL ab_post_data got=%h exp=11112222", dq[0]); end
      idle(0);
   endtask

   task automatic test_reset_hold();
      reset = 1'b0;
      re[0] = 1'b1; we[0] = 1'b0; ad[0] = 32'h10; wd[0] = 32'd0;
      #1;
      checks++; if (stl[0] !== 1'b1) begin failures++; $display("FAIL hold_stall got=%b exp=1", stl[0]); end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, rdy[0]); end
         checks++; if (stl[0] !== 1'b1) begin failures++; $display("FAIL hold_stall2 cyc=%0d got=%b exp=1", i, stl[0]); end
      end
      reset = 1'b1;
      n = -1;
      for (int i = 1; i <= 50 && n < 0; i++) begin
         @(posedge clk); #1;
         if (rdy[0]) n = i;
      end
      checks++; if (n !== 2)                begin failures++; $display("FAIL hold_lat got=%0d exp=2", n); end
      checks++; if (dq[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL hold_data got=%h exp=deadbeef", dq[0]); end
      idle(0);
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_errors();
      test_capture();
      test_reset_abort();
      test_reset_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
